// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Program-counter sequencer for the instruction fetch stage. Produces the
//   current fetch address, advances it on accepted fetches, redirects on taken
//   branches and parks in a sticky fault state on a misaligned branch target.
//
// Parameters
//   RESET_VECTOR  first fetch address after reset
//   STEP          sequential PC increment (modulo 2^32)
//
// Ports
//   clk            single clock, rising edge
//   rst_n          synchronous active-low reset
//   branch_taken   redirect request this cycle
//   branch_target  redirect address (pc_out + offset from the datapath adder)
//   stall          pipeline hazard hold, blocks sequential advance
//   fetch_ready    fetch port accepts pc_out this cycle
//   pc_out         current fetch address (registered)
//   pc_valid       pc_out is a valid fetch request (registered)
//   flush          one-cycle pulse per taken, aligned redirect (registered)
//   fault          sticky misaligned-target indicator (registered)
//   fetch_count    number of accepted fetches, modulo 2^32 (registered)
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] STEP         = 32'd4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        stall,
  input  logic        fetch_ready,
  output logic [31:0] pc_out,
  output logic        pc_valid,
  output logic        flush,
  output logic        fault,
  output logic [31:0] fetch_count
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    FAULT = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] count_q, count_d;
  logic        valid_q, valid_d;
  logic        flush_q, flush_d;
  logic        fault_q, fault_d;

  logic        accept;
  logic        misaligned;

  // valid_q is only ever set in RUN/HOLD, so accept cannot fire in BOOT/FAULT.
  assign accept     = valid_q && fetch_ready && !stall;
  assign misaligned = (branch_target[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    valid_d = valid_q;
    flush_d = 1'b0;
    fault_d = fault_q;

    unique case (state_q)
      BOOT: begin
        // branch_taken is deliberately ignored here
        state_d = RUN;
        valid_d = 1'b1;
      end

      RUN, HOLD: begin
        // The fetch is counted even when a redirect replaces the next PC.
        if (accept) begin
          count_d = count_q + 32'd1;
        end

        if (branch_taken && misaligned) begin
          state_d = FAULT;
          pc_d    = branch_target;
          valid_d = 1'b0;
          fault_d = 1'b1;
        end else if (branch_taken) begin
          state_d = RUN;
          pc_d    = branch_target;
          flush_d = 1'b1;
        end else if (accept) begin
          state_d = RUN;
          pc_d    = pc_q + STEP;
        end else begin
          state_d = HOLD;
        end
      end

      FAULT: begin
        // terminal until reset: everything frozen
      end

      default: begin
        state_d = BOOT;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
      count_q <= '0;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      valid_q <= valid_d;
      flush_q <= flush_d;
      fault_q <= fault_d;
    end
  end

  assign pc_out      = pc_q;
  assign pc_valid    = valid_q;
  assign flush       = flush_q;
  assign fault       = fault_q;
  assign fetch_count = count_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Bench for pc_sequencer. Instance A uses the default reset vector and takes
//   directed then random stimulus; instance B uses RESET_VECTOR=FFFF_FFF8 with
//   continuous accept to exercise address wrap. Both are compared every cycle
//   against a behavioural model of the observable outputs.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] cnt;
    bit          valid;
    bit          flush;
    bit          fault;
    bit          boot;
  } mdl_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        stall;
  logic        fetch_ready;

  logic [31:0] pc_a, cnt_a;
  logic        valid_a, flush_a, fault_a;

  logic        b_bt    = 1'b0;
  logic [31:0] b_tgt   = '0;
  logic        b_stall = 1'b0;
  logic        b_rdy   = 1'b1;
  logic [31:0] pc_b, cnt_b;
  logic        valid_b, flush_b, fault_b;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  mdl_t ma, mb;

  always #5 clk = ~clk;

  pc_sequencer u_dut_a (
    .clk(clk), .rst_n(rst_n), .branch_taken(branch_taken),
    .branch_target(branch_target), .stall(stall), .fetch_ready(fetch_ready),
    .pc_out(pc_a), .pc_valid(valid_a), .flush(flush_a), .fault(fault_a),
    .fetch_count(cnt_a)
  );

  pc_sequencer #(.RESET_VECTOR(32'hFFFF_FFF8), .STEP(32'd4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .branch_taken(b_bt),
    .branch_target(b_tgt), .stall(b_stall), .fetch_ready(b_rdy),
    .pc_out(pc_b), .pc_valid(valid_b), .flush(flush_b), .fault(fault_b),
    .fetch_count(cnt_b)
  );

  // Observable behaviour only: reset, one idle boot cycle, then
  // fault-freeze / misaligned / aligned redirect / accept in priority order.
  function automatic mdl_t mstep(input mdl_t m, input bit rst, input bit bt,
                                 input logic [31:0] tgt, input bit st,
                                 input bit fr, input logic [31:0] rv);
    mdl_t n = m;
    bit   acc;
    if (!rst) begin
      n.pc = rv; n.cnt = 0; n.valid = 0; n.flush = 0; n.fault = 0; n.boot = 1;
    end else if (m.fault) begin
      n.flush = 0;
    end else if (m.boot) begin
      n.boot = 0; n.valid = 1; n.flush = 0;
    end else begin
      acc     = fr && !st;
      n.flush = 0;
      if (acc) n.cnt = m.cnt + 1;
      if (bt && (tgt % 4 != 0)) begin
        n.fault = 1; n.valid = 0; n.pc = tgt;
      end else if (bt) begin
        n.pc = tgt; n.flush = 1;
      end else if (acc) begin
        n.pc = m.pc + 4;
      end
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    ma = mstep(ma, rst_n, branch_taken, branch_target, stall, fetch_ready, 32'h0);
    mb = mstep(mb, rst_n, 1'b0, 32'h0, 1'b0, 1'b1, 32'hFFFF_FFF8);
    #1;
    check("a_pc",    pc_a,            ma.pc);
    check("a_valid", {31'd0, valid_a}, {31'd0, ma.valid});
    check("a_flush", {31'd0, flush_a}, {31'd0, ma.flush});
    check("a_fault", {31'd0, fault_a}, {31'd0, ma.fault});
    check("a_count", cnt_a,           ma.cnt);
    check("b_pc",    pc_b,            mb.pc);
    check("b_valid", {31'd0, valid_b}, {31'd0, mb.valid});
    check("b_count", cnt_b,           mb.cnt);
  endtask

  initial begin
    logic [31:0] t;

    rst_n = 1'b0; branch_taken = 1'b0; branch_target = '0;
    stall = 1'b0; fetch_ready = 1'b1;
    step(); step();
    check("rst_pc",    pc_a, 32'h0);
    check("rst_valid", {31'd0, valid_a}, 32'd0);
    check("rst_count", cnt_a, 32'd0);

    // boot cycle elapsed, sequential fetch
    rst_n = 1'b1;
    step();
    check("boot_pc", pc_a, 32'h0);
    check("boot_valid", {31'd0, valid_a}, 32'd1);
    check("wrap_b0", pc_b, 32'hFFFF_FFF8);
    step();
    check("seq_pc4", pc_a, 32'h4);
    check("seq_cnt1", cnt_a, 32'd1);
    check("wrap_b1", pc_b, 32'hFFFF_FFFC);
    step();
    check("seq_pc8", pc_a, 32'h8);
    check("wrap_b2", pc_b, 32'h0000_0000);
    step();
    check("seq_cnt3", cnt_a, 32'd3);
    check("wrap_b3", pc_b, 32'h0000_0004);
    step();
    check("seq_pc10", pc_a, 32'h10);

    // stall hold for three cycles
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_pc", pc_a, 32'h10);
      check("stall_cnt", cnt_a, 32'd4);
    end
    stall = 1'b0;
    step();
    check("release_pc", pc_a, 32'h14);
    check("release_cnt", cnt_a, 32'd5);

    // redirect to 0x20, then stalled redirect to 0x100
    branch_taken = 1'b1; branch_target = 32'h20;
    step();
    check("br20_pc", pc_a, 32'h20);
    stall = 1'b1; branch_target = 32'h100;
    step();
    check("stall_br_pc", pc_a, 32'h100);
    check("stall_br_flush", {31'd0, flush_a}, 32'd1);
    check("stall_br_cnt", cnt_a, 32'd6);
    stall = 1'b0; branch_taken = 1'b0;
    step();
    check("flush_pulse", {31'd0, flush_a}, 32'd0);

    // redirect to 0x8, then redirect with accept at 0x8 -> 0x80
    branch_taken = 1'b1; branch_target = 32'h8;
    step();
    branch_target = 32'h80;
    step();
    check("acc_br_pc", pc_a, 32'h80);
    check("acc_br_cnt", cnt_a, 32'd9);
    check("acc_br_flush", {31'd0, flush_a}, 32'd1);

    // misaligned redirect from 0x40
    branch_target = 32'h40;
    step();
    branch_target = 32'h102;
    step();
    check("mis_fault", {31'd0, fault_a}, 32'd1);
    check("mis_valid", {31'd0, valid_a}, 32'd0);
    check("mis_pc", pc_a, 32'h102);
    for (int i = 0; i < 5; i++) begin
      branch_taken  = 1'($urandom_range(0, 1));
      branch_target = $urandom();
      stall         = 1'($urandom_range(0, 1));
      fetch_ready   = 1'($urandom_range(0, 1));
      step();
      check("frozen_pc", pc_a, 32'h102);
      check("frozen_fault", {31'd0, fault_a}, 32'd1);
    end
    rst_n = 1'b0; branch_taken = 1'b0; stall = 1'b0; fetch_ready = 1'b1;
    step();
    check("fault_rst_pc", pc_a, 32'h0);
    check("fault_rst_fault", {31'd0, fault_a}, 32'd0);
    rst_n = 1'b1;

    // random traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      rst_n        = ($urandom_range(0, 39) != 0);
      branch_taken = ($urandom_range(0, 4) == 0);
      t = $urandom();
      if ($urandom_range(0, 3) != 0) t[1:0] = 2'b00;
      branch_target = t;
      stall       = ($urandom_range(0, 3) == 0);
      fetch_ready = ($urandom_range(0, 3) != 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
